adc_sequencer: RTL
==================

ADC_SEQUENCER -- requirements
Module: adc_sequencer

Interface
REQ-001 Parameter NUM_CH, default 5, number of channels converted per frame (2..8).
REQ-002 Parameter DATA_W, default 12, conversion result width.
REQ-003 Parameter TIMEOUT, default 64, cycles allowed for conv_done (used only with SEQ_TIMEOUT_EN).
REQ-004 clk  input  1  single clock, all state on posedge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 tick  input  1  one-cycle frame trigger pulse from the period downcounter's zero output.
REQ-007 conv_start  output  1  one-cycle request to the ADC front end.
REQ-008 conv_chan  output  3  channel index for the current conversion.
REQ-009 conv_done  input  1  one-cycle completion pulse from the ADC front end.
REQ-010 conv_data  input  DATA_W  result, valid only while conv_done is high.
REQ-011 out_valid / out_ready  output / input  1 / 1  result stream handshake.
REQ-012 out_data  output  DATA_W  captured result.
REQ-013 out_chan  output  3  channel of out_data.
REQ-014 out_err  output  1  marks a timed-out (substituted) result.
REQ-015 overrun  output  1  sticky: tick arrived while a frame was in progress.
REQ-016 clr_overrun  input  1  clears overrun.
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 FSM states IDLE, START, WAIT, OUT; all outputs registered.
REQ-019 IDLE: tick=1 -> START with channel counter 0; tick=0 -> stay.
REQ-020 START: conv_start=1 and conv_chan=counter for exactly one cycle, then WAIT; tick in cycle n in IDLE gives conv_start high in cycle n+1.
REQ-021 WAIT: conv_done=1 -> latch conv_data into out_data, counter into out_chan, out_err=0, go OUT; out_valid high the cycle after conv_done.
REQ-022 conv_done outside WAIT is ignored, no state change.
REQ-023 OUT: out_valid held high, out_data/out_chan/out_err stable until out_valid & out_ready.
REQ-024 On handshake: counter==NUM_CH-1 -> IDLE, counter cleared; else counter+1 and START (next conv_start the following cycle).
REQ-025 Channel counter never exceeds NUM_CH-1; no wrap beyond within a frame.
REQ-026 tick while state != IDLE (including the final-handshake cycle) is dropped and sets overrun the next cycle.
REQ-027 clr_overrun clears overrun; simultaneous tick-overrun and clr_overrun -> overrun stays 1 (set wins).
REQ-028 busy = (state != IDLE), registered with state.

Reset
REQ-029 reset asserted -> state IDLE, counter 0, conv_start 0, conv_chan 0, out_valid 0, out_data 0, out_chan 0, out_err 0, overrun 0, busy 0, immediately and asynchronously.
REQ-030 Reset mid-frame abandons the frame; no partial output after release; first post-reset tick starts channel 0.

Configuration
REQ-031 Macro SEQ_TIMEOUT_EN defined: WAIT counts cycles; TIMEOUT cycles without conv_done -> out_data all ones, out_err=1, go OUT and continue frame normally; conv_done in the same cycle as expiry wins (normal capture).
REQ-032 SEQ_TIMEOUT_EN undefined: no timeout counter, WAIT holds indefinitely, out_err tied 0, TIMEOUT unused.

Verification
REQ-033 Reset, tick, conv_done 3 cycles after each conv_start with data 0x100+ch, out_ready=1 -> 5 results chan 0..4, data 0x100..0x104, then busy 0.
REQ-034 out_ready low 10 cycles on chan 2 -> out_valid/out_data 0x102 held stable, no conv_start for chan 3 until handshake.
REQ-035 Second tick during chan 1 wait -> overrun=1, frame completes with 5 results only; clr_overrun -> overrun 0.
REQ-036 conv_done pulse while in IDLE or OUT -> no output change, no state change.
REQ-037 SEQ_TIMEOUT_EN, TIMEOUT=64, withhold conv_done on chan 3 -> after 64 cycles out_data 0xFFF, out_err=1, chan 3, then chan 4 converts normally.
REQ-038 reset asserted during OUT on chan 1 -> all outputs 0 immediately; next tick yields conv_chan 0.

Source files
------------

// File: rtl/adc_sequencer.sv
// adc_sequencer: per-frame ADC channel sequencer with a ready/valid result stream.
// On each frame tick it converts channels 0..NUM_CH-1 in order, one result at a time.
// Optional feature macro: SEQ_TIMEOUT_EN. When it is defined, a conversion that gets
// no conv_done within TIMEOUT cycles yields an all-ones result flagged by out_err.
module adc_sequencer #(
    parameter int unsigned NUM_CH  = 5,
    parameter int unsigned DATA_W  = 12,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    output logic              conv_start,
    output logic [2:0]        conv_chan,
    input  logic              conv_done,
    input  logic [DATA_W-1:0] conv_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [2:0]        out_chan,
    output logic              out_err,
    output logic              overrun,
    input  logic              clr_overrun,
    output logic              busy
);

    localparam int unsigned CH_W    = 3;
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t          state;
    logic [CH_W-1:0] cnt;
    logic            tmo_hit_c;

    // Elaboration-time parameter range checks
    if (NUM_CH < 2 || NUM_CH > 8) begin : g_bad_num_ch
        $error("adc_sequencer: NUM_CH must be in 2..8");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("adc_sequencer: TIMEOUT must be at least 1");
    end

`ifdef SEQ_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

    logic [TMO_W-1:0] tmo_cnt;

    // Count cycles spent waiting for conv_done; restarts on every entry to WAIT
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt <= '0;
        end else if (state == WAIT && !conv_done) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end else begin
            tmo_cnt <= '0;
        end
    end

    assign tmo_hit_c = (state == WAIT) && (tmo_cnt == TMO_W'(TIMEOUT - 1));
`else
    assign tmo_hit_c = 1'b0;
`endif

    // Sequencer FSM with registered outputs and sticky overrun flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            conv_start <= 1'b0;
            conv_chan  <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_chan   <= '0;
            out_err    <= 1'b0;
            overrun    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            // A tick that lands mid-frame is dropped; setting beats clearing
            if (tick && state != IDLE) begin
                overrun <= 1'b1;
            end else if (clr_overrun) begin
                overrun <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (tick) begin
                        state      <= START;
                        cnt        <= '0;
                        conv_start <= 1'b1;
                        conv_chan  <= '0;
                        busy       <= 1'b1;
                    end
                end
                START: begin
                    conv_start <= 1'b0;
                    state      <= WAIT;
                end
                WAIT: begin
                    // A real result in the expiry cycle takes priority over the timeout
                    if (conv_done) begin
                        out_data  <= conv_data;
                        out_chan  <= cnt;
                        out_err   <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= OUT;
                    end else if (tmo_hit_c) begin
                        out_data  <= '1;
                        out_chan  <= cnt;
                        out_err   <= 1'b1;
                        out_valid <= 1'b1;
                        state     <= OUT;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (cnt == LAST_CH) begin
                            state <= IDLE;
                            cnt   <= '0;
                            busy  <= 1'b0;
                        end else begin
                            cnt        <= cnt + CH_W'(1);
                            conv_chan  <= cnt + CH_W'(1);
                            conv_start <= 1'b1;
                            state      <= START;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
